main_fsm: RTL and testbench

Multicycle main controller for the RISC-V core. It sequences the shared ALU, the unified instruction/data memory port, the PC, the instruction register and the register file across fetch, decode, execute, memory and writeback states. It drives `ALUOp` into `Alu_Decoder` and all datapath mux selects and write strobes. It replaces the single-cycle main decoder when the core is built in multicycle mode.

---
 rtl/main_fsm.sv | 169 ++++++++++++++++
 tb/tb_main_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/main_fsm.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects, write strobes and ALUOp for Alu_Decoder.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       funct3b0,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    typedef enum logic [6:0] {
        OP_LW     = 7'b0000011,
        OP_SW     = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_I      = 7'b0010011,
        OP_JAL    = 7'b1101111,
        OP_BRANCH = 7'b1100011
    } opcode_t;

    state_t state_q, state_d;

    logic pc_write_raw, mem_write_raw, ir_write_raw, reg_write_raw, illegal_raw;
    logic [1:0] imm_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        imm_dec = 2'b00;
        case (op)
            OP_LW, OP_I: imm_dec = 2'b00;
            OP_SW:       imm_dec = 2'b01;
            OP_BRANCH:   imm_dec = 2'b10;
            OP_JAL:      imm_dec = 2'b11;
            default:     imm_dec = 2'b00;
        endcase
    end

    always_comb begin
        state_d       = FETCH;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        ImmSrc        = imm_dec;

        case (state_q)
            FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = mem_ready;
                pc_write_raw = mem_ready;
                state_d      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_JAL:       state_d = JAL;
                    OP_BRANCH:    state_d = BRANCH;
                    default: begin
                        state_d     = FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            JAL: begin
                ALUSrcA      = 2'b01;
                ALUSrcB      = 2'b10;
                pc_write_raw = 1'b1;
                state_d      = ALUWB;
            end
            BRANCH: begin
                ALUSrcA      = 2'b10;
                ALUOp        = 2'b01;
                pc_write_raw = zero ^ funct3b0;
                state_d      = FETCH;
            end
            default: begin
                // Unreachable encodings: recover to FETCH with every output quiet.
                ImmSrc  = 2'b00;
                state_d = FETCH;
            end
        endcase
    end

    assign PCWrite  = pc_write_raw  & ~reset;
    assign MemWrite = mem_write_raw & ~reset;
    assign IRWrite  = ir_write_raw  & ~reset;
    assign RegWrite = reg_write_raw & ~reset;
    assign illegal  = illegal_raw   & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed self-checking bench for main_fsm: state traces, strobes and selects
// against hand-derived values, including stalls, illegal opcodes and mid-flight reset.
module tb_main_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       funct3b0;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct3b0  (funct3b0),
        .zero      (zero),
        .mem_ready (mem_ready),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .illegal   (illegal),
        .state     (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then let combinational outputs settle before checking.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000011; funct3b0 = 1'b0; zero = 1'b0; mem_ready = 1'b1;

        // Reset held for two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_state", state, 0);
            check("rst_strobes", {PCWrite, IRWrite, MemWrite, RegWrite, illegal}, 0);
        end
        reset = 1'b0;
        #1;
        check("fetch_irw", IRWrite, 1);
        check("fetch_pcw", PCWrite, 1);
        check("fetch_sel", {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc}, 9'b0_00_10_00_10);

        // lw: 0,1,2,3,4,0
        tick(); check("lw_s1", state, 1); check("lw_imm", ImmSrc, 0);
        check("dec_sel", {ALUSrcA, ALUSrcB, ALUOp}, 6'b01_01_00);
        tick(); check("lw_s2", state, 2); check("lw_aluop", ALUOp, 0); check("lw_srca", ALUSrcA, 2);
        tick(); check("lw_s3", state, 3); check("lw_rw3", RegWrite, 0); check("lw_adr", AdrSrc, 1);
        tick(); check("lw_s4", state, 4); check("lw_rw4", RegWrite, 1); check("lw_res", ResultSrc, 1);
        tick(); check("lw_s0", state, 0); check("lw_rw0", RegWrite, 0);

        // R-type: 0,1,6,8,0
        op = 7'b0110011;
        tick(); check("r_s1", state, 1);
        tick(); check("r_s6", state, 6); check("r_aluop", ALUOp, 2); check("r_srcb", ALUSrcB, 0);
        tick(); check("r_s8", state, 8); check("r_rw", RegWrite, 1); check("r_res", ResultSrc, 0);
        tick(); check("r_s0", state, 0);

        // I-type: 0,1,7,8,0
        op = 7'b0010011;
        tick(); check("i_s1", state, 1);
        tick(); check("i_s7", state, 7); check("i_aluop", ALUOp, 2); check("i_srcb", ALUSrcB, 1);
        tick(); check("i_s8", state, 8);
        tick(); check("i_s0", state, 0);

        // Branches: {funct3b0, zero, expected PCWrite}
        op = 7'b1100011;
        for (int k = 0; k < 3; k++) begin
            logic [2:0] v;
            v = (k == 0) ? 3'b011 : (k == 1) ? 3'b000 : 3'b101;
            funct3b0 = v[2]; zero = v[1];
            tick(); check("br_s1", state, 1); check("br_imm", ImmSrc, 2);
            check("br_dec_pcw", PCWrite, 0);
            tick(); check("br_s10", state, 10); check("br_aluop", ALUOp, 1);
            check("br_imm10", ImmSrc, 2); check("br_pcw", PCWrite, {31'd0, v[0]});
            tick(); check("br_s0", state, 0);
        end
        funct3b0 = 1'b0; zero = 1'b0;

        // sw with 3 stall cycles in MEMWRITE
        op = 7'b0100011;
        tick(); check("sw_s1", state, 1); check("sw_imm", ImmSrc, 1);
        tick(); check("sw_s2", state, 2); check("sw_mw2", MemWrite, 0);
        mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick(); check("sw_s5", state, 5); check("sw_mw", MemWrite, 1);
        end
        mem_ready = 1'b1;
        #1; check("sw_mw_last", MemWrite, 1);
        tick(); check("sw_s0", state, 0); check("sw_mw0", MemWrite, 0);

        // Fetch stall, then illegal opcode 0,1,0
        mem_ready = 1'b0; op = 7'b1111111;
        #1; check("fst_irw", IRWrite, 0); check("fst_pcw", PCWrite, 0);
        tick(); check("fst_s0", state, 0);
        mem_ready = 1'b1;
        #1; check("fst_irw1", IRWrite, 1);
        tick(); check("ill_s1", state, 1); check("ill_flag", illegal, 1);
        tick(); check("ill_s0", state, 0); check("ill_clr", illegal, 0);

        // Reset asserted while in MEMREAD
        op = 7'b0000011;
        tick(); tick(); tick(); check("rr_s3", state, 3);
        mem_ready = 1'b0; reset = 1'b1;
        #1; check("rr_strobes", {PCWrite, IRWrite, MemWrite, RegWrite, illegal}, 0);
        tick(); check("rr_s0", state, 0);
        reset = 1'b0; mem_ready = 1'b1;

        // jal: 0,1,9,8,0
        op = 7'b1101111;
        tick(); check("jal_s1", state, 1); check("jal_imm", ImmSrc, 3);
        tick(); check("jal_s9", state, 9); check("jal_pcw", PCWrite, 1);
        check("jal_sel", {ALUSrcA, ALUSrcB, ALUOp, ResultSrc}, 8'b01_10_00_00);
        tick(); check("jal_s8", state, 8); check("jal_rw", RegWrite, 1); check("jal_pcw8", PCWrite, 0);
        tick(); check("jal_s0", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
